// File: rtl/adc_power_monitor.sv
// Passive statistics monitor on one RFDC ADC AXI4-Stream (8 x int16 per beat): sum of squares,
// peak |x| and clipped-sample count over acc_len beats, held in result registers.
module adc_power_monitor #(
    parameter int LEN_W  = 16,
    parameter int ACC_W  = 50,
    parameter int CLIP_W = 16
) (
    input  logic              axis_clk,
    input  logic              axis_arst_n,
    input  logic [127:0]      s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              start,
    input  logic              abort,
    input  logic              continuous,
    input  logic [LEN_W-1:0]  acc_len,
    output logic              busy,
    output logic              result_valid,
    output logic [ACC_W-1:0]  pow_sum,
    output logic              pow_sat,
    output logic [16:0]       peak_abs,
    output logic [CLIP_W-1:0] clip_cnt
);
    localparam int SUM_W = 34;
    localparam int EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;
    localparam logic [EXT_W-1:0]  POW_MAX  = {{(EXT_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};
    localparam logic [CLIP_W:0]   CLIP_MAX = {1'b0, {CLIP_W{1'b1}}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // 31-bit signed product keeps exactly the bits of x^2 (max 2^30)
    function automatic logic [30:0] sq_f(input logic [15:0] v);
        logic signed [30:0] x;
        x = {{15{v[15]}}, v};
        return x * x;
    endfunction

    function automatic logic [16:0] abs_f(input logic [15:0] v);
        logic [16:0] e;
        e = {v[15], v};
        return v[15] ? (~e + 17'd1) : e;
    endfunction

    function automatic logic clip_f(input logic [15:0] v);
        return (v == 16'h7FFF) || (v == 16'h8000);
    endfunction

    logic [1:0]       rst_sync_r;
    logic             rst_n_s;
    state_t           state_r;
    logic [LEN_W-1:0] cnt_r;
    logic             first_pend_r;
    logic             tready_r;
    logic [LEN_W-1:0] len_s;
    logic             beat_s;
    logic             last_s;
    logic             run_next_s;

    // reset synchroniser: asserts asynchronously, releases on the clock
    always_ff @(posedge axis_clk or negedge axis_arst_n) begin
        if (!axis_arst_n) rst_sync_r <= 2'b00;
        else              rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
    assign rst_n_s = rst_sync_r[1];

    // frame control decode
    always_comb begin
        len_s      = (acc_len == {LEN_W{1'b0}}) ? LEN_ONE : acc_len;
        beat_s     = s_axis_tvalid & tready_r & (state_r == RUN) & ~abort;
        last_s     = beat_s & (cnt_r == LEN_ONE);
        run_next_s = ~abort & (((state_r == IDLE) & start) |
                               ((state_r == RUN) & ~(last_s & ~continuous)));
    end

    // IDLE/RUN frame FSM with beat counter
    always_ff @(posedge axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r      <= IDLE;
            cnt_r        <= {LEN_W{1'b0}};
            first_pend_r <= 1'b0;
            tready_r     <= 1'b0;
        end else begin
            tready_r <= 1'b1;
            if (abort) begin
                state_r      <= IDLE;
                first_pend_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            state_r      <= RUN;
                            cnt_r        <= len_s;
                            first_pend_r <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (last_s) begin
                            cnt_r        <= len_s;
                            first_pend_r <= 1'b1;
                            state_r      <= continuous ? RUN : IDLE;
                        end else if (beat_s) begin
                            cnt_r        <= cnt_r - LEN_ONE;
                            first_pend_r <= 1'b0;
                        end
                    end
                    default: state_r <= IDLE;
                endcase
            end
        end
    end

    logic        v1_r, f1_r, l1_r;
    logic [30:0] sq1_r  [8];
    logic [16:0] abs1_r [8];
    logic [7:0]  clip1_r;

    // S1: per-lane square, magnitude and clip flag
    always_ff @(posedge axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            v1_r    <= 1'b0;
            f1_r    <= 1'b0;
            l1_r    <= 1'b0;
            clip1_r <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                sq1_r[i]  <= 31'd0;
                abs1_r[i] <= 17'd0;
            end
        end else begin
            v1_r <= beat_s;
            f1_r <= first_pend_r;
            l1_r <= last_s;
            for (int i = 0; i < 8; i++) begin
                sq1_r[i]   <= sq_f(s_axis_tdata[16*i +: 16]);
                abs1_r[i]  <= abs_f(s_axis_tdata[16*i +: 16]);
                clip1_r[i] <= clip_f(s_axis_tdata[16*i +: 16]);
            end
        end
    end

    logic [SUM_W-1:0] sum_s;
    logic [16:0]      max_s;
    logic [3:0]       pop_s;

    // S2 lane reduction
    always_comb begin
        sum_s = {SUM_W{1'b0}};
        max_s = 17'd0;
        pop_s = 4'd0;
        for (int i = 0; i < 8; i++) begin
            sum_s = sum_s + {3'b000, sq1_r[i]};
            max_s = (abs1_r[i] > max_s) ? abs1_r[i] : max_s;
            pop_s = pop_s + {3'b000, clip1_r[i]};
        end
    end

    logic             v2_r, f2_r, l2_r;
    logic [SUM_W-1:0] sum2_r;
    logic [16:0]      max2_r;
    logic [3:0]       pop2_r;

    // S2 registers
    always_ff @(posedge axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            v2_r   <= 1'b0;
            f2_r   <= 1'b0;
            l2_r   <= 1'b0;
            sum2_r <= {SUM_W{1'b0}};
            max2_r <= 17'd0;
            pop2_r <= 4'd0;
        end else begin
            v2_r   <= v1_r & ~abort;
            f2_r   <= f1_r;
            l2_r   <= l1_r;
            sum2_r <= sum_s;
            max2_r <= max_s;
            pop2_r <= pop_s;
        end
    end

    logic              acc_v_r, acc_l_r, acc_sat_r;
    logic [ACC_W-1:0]  acc_pow_r;
    logic [16:0]       acc_peak_r;
    logic [CLIP_W-1:0] acc_clip_r;
    logic [EXT_W-1:0]  pow_tot_s;
    logic              pow_ovf_s;
    logic [CLIP_W:0]   clip_tot_s;
    logic [ACC_W-1:0]  pow_new_s;
    logic              sat_new_s;
    logic [16:0]       peak_new_s;
    logic [CLIP_W-1:0] clip_new_s;

    // S3 saturating accumulate; a 'first' beat restarts from zero
    always_comb begin
        pow_tot_s  = (f2_r ? {EXT_W{1'b0}} : {{(EXT_W-ACC_W){1'b0}}, acc_pow_r}) +
                     {{(EXT_W-SUM_W){1'b0}}, sum2_r};
        pow_ovf_s  = pow_tot_s > POW_MAX;
        pow_new_s  = pow_ovf_s ? {ACC_W{1'b1}} : pow_tot_s[ACC_W-1:0];
        sat_new_s  = pow_ovf_s | (~f2_r & acc_sat_r);
        peak_new_s = (f2_r || (max2_r > acc_peak_r)) ? max2_r : acc_peak_r;
        clip_tot_s = (f2_r ? {(CLIP_W+1){1'b0}} : {1'b0, acc_clip_r}) +
                     {{(CLIP_W-3){1'b0}}, pop2_r};
        clip_new_s = (clip_tot_s > CLIP_MAX) ? {CLIP_W{1'b1}} : clip_tot_s[CLIP_W-1:0];
    end

    // S3 accumulator registers
    always_ff @(posedge axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            acc_v_r    <= 1'b0;
            acc_l_r    <= 1'b0;
            acc_sat_r  <= 1'b0;
            acc_pow_r  <= {ACC_W{1'b0}};
            acc_peak_r <= 17'd0;
            acc_clip_r <= {CLIP_W{1'b0}};
        end else begin
            acc_v_r <= v2_r & ~abort;
            acc_l_r <= l2_r;
            if (v2_r && !abort) begin
                acc_sat_r  <= sat_new_s;
                acc_pow_r  <= pow_new_s;
                acc_peak_r <= peak_new_s;
                acc_clip_r <= clip_new_s;
            end
        end
    end

    logic              busy_r, rv_r, sat_r;
    logic [ACC_W-1:0]  pow_r;
    logic [16:0]       peak_r;
    logic [CLIP_W-1:0] clip_r;

    // result registers and busy; busy covers RUN plus a final frame still in the pipeline
    always_ff @(posedge axis_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            busy_r <= 1'b0;
            rv_r   <= 1'b0;
            sat_r  <= 1'b0;
            pow_r  <= {ACC_W{1'b0}};
            peak_r <= 17'd0;
            clip_r <= {CLIP_W{1'b0}};
        end else begin
            busy_r <= run_next_s | (~abort & (last_s | (v1_r & l1_r) | (v2_r & l2_r)));
            rv_r   <= acc_v_r & acc_l_r & ~abort;
            if (acc_v_r && acc_l_r && !abort) begin
                sat_r  <= acc_sat_r;
                pow_r  <= acc_pow_r;
                peak_r <= acc_peak_r;
                clip_r <= acc_clip_r;
            end
        end
    end

    assign s_axis_tready = tready_r;
    assign busy          = busy_r;
    assign result_valid  = rv_r;
    assign pow_sum       = pow_r;
    assign pow_sat       = sat_r;
    assign peak_abs      = peak_r;
    assign clip_cnt      = clip_r;
endmodule

// File: tb/tb_adc_power_monitor.sv
// Directed bench for adc_power_monitor; a second instance with ACC_W=34 exercises power saturation.
module tb_adc_power_monitor;
    logic         clk = 1'b0;
    logic         arst_n;
    logic [127:0] tdata;
    logic         tvalid, start, abort, continuous;
    logic [15:0]  acc_len;
    logic         tready, busy, result_valid, pow_sat;
    logic [49:0]  pow_sum;
    logic [16:0]  peak_abs;
    logic [15:0]  clip_cnt;
    logic         tready34, busy34, rv34, pow_sat34;
    logic [33:0]  pow_sum34;
    logic [16:0]  peak34;
    logic [15:0]  clip34;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adc_power_monitor dut (
        .axis_clk(clk), .axis_arst_n(arst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready), .start(start), .abort(abort), .continuous(continuous),
        .acc_len(acc_len), .busy(busy), .result_valid(result_valid), .pow_sum(pow_sum),
        .pow_sat(pow_sat), .peak_abs(peak_abs), .clip_cnt(clip_cnt)
    );

    adc_power_monitor #(.ACC_W(34)) dut34 (
        .axis_clk(clk), .axis_arst_n(arst_n), .s_axis_tdata(tdata), .s_axis_tvalid(tvalid),
        .s_axis_tready(tready34), .start(start), .abort(abort), .continuous(continuous),
        .acc_len(acc_len), .busy(busy34), .result_valid(rv34), .pow_sum(pow_sum34),
        .pow_sat(pow_sat34), .peak_abs(peak34), .clip_cnt(clip34)
    );

    task automatic drive_beat(input logic [15:0] v);
        tdata  = {8{v}};
        tvalid = 1'b1;
        @(negedge clk);
    endtask

    task automatic start_frame(input logic [15:0] len, input logic cont);
        start      = 1'b1;
        acc_len    = len;
        continuous = cont;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat    = -1;
        tvalid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (result_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        arst_n = 1'b0; tdata = 128'd0; tvalid = 1'b0; start = 1'b0;
        abort = 1'b0; continuous = 1'b0; acc_len = 16'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tready, tready34, busy, result_valid, pow_sat} !== 5'b00000 || pow_sum !== 50'd0 ||
            peak_abs !== 17'd0 || clip_cnt !== 16'd0)
            begin errors++; $display("FAIL reset_outputs: tready=%b busy=%b rv=%b pow=%0d expected all 0", tready, busy, result_valid, pow_sum); end
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", tready); end
    endtask

    task automatic test_basic;
        int lat;
        start_frame(16'd4, 1'b0);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        repeat (4) drive_beat(16'h1000);
        wait_result(lat);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
        checks++;
        if (pow_sum !== 50'd536870912) begin errors++; $display("FAIL basic_pow: got %0d expected 536870912", pow_sum); end
        checks++;
        if (peak_abs !== 17'd4096 || clip_cnt !== 16'd0 || pow_sat !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL basic_misc: peak=%0d clip=%0d sat=%b busy=%b expected 4096 0 0 0", peak_abs, clip_cnt, pow_sat, busy); end
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || pow_sum !== 50'd536870912)
            begin errors++; $display("FAIL basic_pulse_hold: rv=%b pow=%0d expected 0 536870912", result_valid, pow_sum); end
    endtask

    task automatic test_clip;
        int lat;
        start_frame(16'd1, 1'b0);
        tdata  = {96'd0, 16'h7FFF, 16'h8000};
        tvalid = 1'b1;
        @(negedge clk);
        wait_result(lat);
        checks++;
        if (lat !== 3 || pow_sum !== 50'd2147418113)
            begin errors++; $display("FAIL clip_pow: lat=%0d pow=%0d expected 3 2147418113", lat, pow_sum); end
        checks++;
        if (peak_abs !== 17'd32768 || clip_cnt !== 16'd2)
            begin errors++; $display("FAIL clip_peak_cnt: peak=%0d clip=%0d expected 32768 2", peak_abs, clip_cnt); end
    endtask

    task automatic test_continuous;
        logic [11:0] pat;
        logic [49:0] exp_pow [3];
        logic [16:0] exp_peak [3];
        int b, nres;
        pat = 12'b101101001101;
        exp_pow[0] = 50'd40000000;  exp_peak[0] = 17'd2000;
        exp_pow[1] = 50'd200000000; exp_peak[1] = 17'd4000;
        exp_pow[2] = 50'd488000000; exp_peak[2] = 17'd6000;
        b = 0; nres = 0;
        start_frame(16'd2, 1'b1);
        for (int t = 0; t < 40; t++) begin
            if (result_valid) begin
                checks++;
                if (nres > 2 || pow_sum !== exp_pow[nres % 3] || peak_abs !== exp_peak[nres % 3])
                    begin errors++; $display("FAIL cont_frame%0d: pow=%0d peak=%0d expected %0d %0d", nres, pow_sum, peak_abs, exp_pow[nres % 3], exp_peak[nres % 3]); end
                nres++;
            end
            if (b < 6 && pat[t % 12]) begin
                tdata      = {8{16'((b + 1) * 1000)}};
                tvalid     = 1'b1;
                continuous = (b <= 3);
                b++;
            end else begin
                tvalid = 1'b0;
            end
            @(negedge clk);
        end
        continuous = 1'b0;
        checks++;
        if (nres !== 3 || busy !== 1'b0)
            begin errors++; $display("FAIL cont_count: results=%0d busy=%b expected 3 0", nres, busy); end
    endtask

    task automatic test_saturation;
        int lat;
        start_frame(16'd4, 1'b0);
        repeat (4) drive_beat(16'h8000);
        wait_result(lat);
        checks++;
        if (rv34 !== 1'b1 || pow_sum34 !== 34'h3_FFFF_FFFF || pow_sat34 !== 1'b1)
            begin errors++; $display("FAIL sat34: rv=%b pow=%0d sat=%b expected 1 17179869183 1", rv34, pow_sum34, pow_sat34); end
        checks++;
        if (pow_sum !== 50'd34359738368 || pow_sat !== 1'b0)
            begin errors++; $display("FAIL sat50: pow=%0d sat=%b expected 34359738368 0", pow_sum, pow_sat); end
        checks++;
        if (clip_cnt !== 16'd32 || peak_abs !== 17'd32768 || clip34 !== 16'd32 || peak34 !== 17'd32768 || busy34 !== 1'b0)
            begin errors++; $display("FAIL sat_clip: clip=%0d peak=%0d busy34=%b expected 32 32768 0", clip_cnt, peak_abs, busy34); end
    endtask

    task automatic test_abort;
        int nres;
        nres = 0;
        start_frame(16'd4, 1'b0);
        repeat (2) drive_beat(16'h0100);
        tvalid = 1'b0;
        abort  = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        repeat (4) begin
            if (result_valid) nres++;
            @(negedge clk);
        end
        start_frame(16'd1, 1'b0);
        drive_beat(16'h0010);
        tvalid = 1'b0;
        repeat (8) begin
            if (result_valid) begin
                nres++;
                checks++;
                if (pow_sum !== 50'd2048) begin errors++; $display("FAIL abort_pow: got %0d expected 2048", pow_sum); end
            end
            @(negedge clk);
        end
        checks++;
        if (nres !== 1) begin errors++; $display("FAIL abort_results: got %0d expected 1", nres); end
        start_frame(16'd4, 1'b0);
        drive_beat(16'h0100);
        tvalid = 1'b0;
        arst_n = 1'b0;
        #1;
        checks++;
        if ({tready, busy, result_valid, pow_sat} !== 4'b0000 || pow_sum !== 50'd0 ||
            peak_abs !== 17'd0 || clip_cnt !== 16'd0)
            begin errors++; $display("FAIL async_reset: busy=%b pow=%0d peak=%0d expected all 0", busy, pow_sum, peak_abs); end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_len_edge;
        int lat;
        start_frame(16'd0, 1'b0);
        drive_beat(16'hFFFF);
        wait_result(lat);
        checks++;
        if (lat !== 3 || pow_sum !== 50'd8 || peak_abs !== 17'd1)
            begin errors++; $display("FAIL len_zero: lat=%0d pow=%0d peak=%0d expected 3 8 1", lat, pow_sum, peak_abs); end
        start_frame(16'd2, 1'b0);
        start   = 1'b1;
        acc_len = 16'd1;
        drive_beat(16'h0002);
        start = 1'b0;
        drive_beat(16'h0003);
        wait_result(lat);
        checks++;
        if (lat !== 3 || pow_sum !== 50'd104 || peak_abs !== 17'd3)
            begin errors++; $display("FAIL start_in_run: lat=%0d pow=%0d peak=%0d expected 3 104 3", lat, pow_sum, peak_abs); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clip();
        test_continuous();
        test_saturation();
        test_abort();
        test_len_edge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
